// File: rtl/nv_nvdla_cdp_rdma_pkg.sv
// Shared types and constants for the CDP RDMA credit scheduler slice.
// Optional check logic in users of this package is enabled by NVDLA_CDP_RDMA_CDT_CHK_EN.
package nv_nvdla_cdp_rdma_pkg;

  localparam int unsigned REQ_PD_W           = 79;
  localparam int unsigned ADDR_LSB           = 0;
  localparam int unsigned ADDR_MSB           = 63;
  localparam int unsigned SIZE_LSB           = 64;
  localparam int unsigned SIZE_MSB           = 78;
  localparam int unsigned ADDR_W             = ADDR_MSB - ADDR_LSB + 1;
  localparam int unsigned SIZE_W             = SIZE_MSB - SIZE_LSB + 1;
  localparam int unsigned NEED_W             = 16;
  localparam int unsigned LAT_FIFO_DEPTH_DEF = 256;
  localparam int unsigned CDT_W_DEF          = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
  } req_pd_t;

  // Atoms requested: size field holds atoms minus one.
  function automatic logic [NEED_W-1:0] req_need(input logic [REQ_PD_W-1:0] pd);
    req_pd_t p;
    p = req_pd_t'(pd);
    return NEED_W'(p.size) + NEED_W'(1);
  endfunction

endpackage

// File: rtl/nv_nvdla_cdp_rdma_cdt_cnt.sv
// Latency-FIFO credit counter: subtract on acceptance, add up to two pops, clamp at depth.
// NVDLA_CDP_RDMA_CDT_CHK_EN exposes the over-return flag.
module nv_nvdla_cdp_rdma_cdt_cnt
  import nv_nvdla_cdp_rdma_pkg::*;
#(
  parameter int unsigned LAT_FIFO_DEPTH = LAT_FIFO_DEPTH_DEF,
  parameter int unsigned CDT_W          = CDT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_acc,
  input  logic [NEED_W-1:0] i_need,
  input  logic              i_pop_a,
  input  logic              i_pop_b,
`ifdef NVDLA_CDP_RDMA_CDT_CHK_EN
  output logic              o_ovf,
`endif
  output logic [CDT_W-1:0]  o_cdt_avail
);

  localparam int unsigned SUM_W = NEED_W + 1;

  logic [CDT_W-1:0] r_cdt_avail;
  logic [SUM_W-1:0] w_sub;
  logic [SUM_W-1:0] w_sum;
  logic             w_ovf;

  // Acceptance is only granted when need fits, so the subtraction never wraps.
  assign w_sub = i_acc ? SUM_W'(i_need) : '0;
  assign w_sum = SUM_W'(r_cdt_avail) - w_sub + SUM_W'(i_pop_a) + SUM_W'(i_pop_b);
  assign w_ovf = (w_sum > SUM_W'(LAT_FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdt_avail <= CDT_W'(LAT_FIFO_DEPTH);
    end else begin
      r_cdt_avail <= w_ovf ? CDT_W'(LAT_FIFO_DEPTH) : CDT_W'(w_sum);
    end
  end

  assign o_cdt_avail = r_cdt_avail;
`ifdef NVDLA_CDP_RDMA_CDT_CHK_EN
  assign o_ovf       = w_ovf;
`endif

endmodule

// File: rtl/nv_nvdla_cdp_rdma_cdt_sched.sv
// Credit-gated read-request scheduler routing ingress requests to mcif or cvif.
// NVDLA_CDP_RDMA_CDT_CHK_EN builds the sticky cdt_err checker; otherwise cdt_err is tied low.
module nv_nvdla_cdp_rdma_cdt_sched
  import nv_nvdla_cdp_rdma_pkg::*;
#(
  parameter int unsigned LAT_FIFO_DEPTH = LAT_FIFO_DEPTH_DEF,
  parameter int unsigned CDT_W          = CDT_W_DEF
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                op_load,
  input  logic                reg2dp_src_ram_type,
  input  logic                layer_end,
  input  logic                ig_req_valid,
  output logic                ig_req_ready,
  input  logic [REQ_PD_W-1:0] ig_req_pd,
  output logic                cdp2mcif_rd_req_valid,
  input  logic                cdp2mcif_rd_req_ready,
  output logic [REQ_PD_W-1:0] cdp2mcif_rd_req_pd,
  output logic                cdp2cvif_rd_req_valid,
  input  logic                cdp2cvif_rd_req_ready,
  output logic [REQ_PD_W-1:0] cdp2cvif_rd_req_pd,
  input  logic                mcif_cdt_pop,
  input  logic                cvif_cdt_pop,
  output logic                sched_done,
  output logic [31:0]         dp2reg_perf_read_stall,
  output logic                cdt_err
);

  sched_state_e        r_state;
  sched_state_e        w_state_nxt;
  logic                r_ram_type;
  logic                r_out_vld;
  logic [REQ_PD_W-1:0] r_out_pd;
  logic [31:0]         r_stall;
  logic [CDT_W-1:0]    w_cdt_avail;
  logic [NEED_W-1:0]   w_need;
  logic                w_sel_ready;
  logic                w_accept;
  logic                w_drained;
  logic                w_op_start;

  assign w_need       = req_need(ig_req_pd);
  assign w_sel_ready  = r_ram_type ? cdp2mcif_rd_req_ready : cdp2cvif_rd_req_ready;
  assign ig_req_ready = (r_state == RUN) && (!r_out_vld || w_sel_ready) &&
                        (w_need <= NEED_W'(w_cdt_avail));
  assign w_accept     = ig_req_valid && ig_req_ready;
  assign w_drained    = !r_out_vld && (w_cdt_avail == CDT_W'(LAT_FIFO_DEPTH));
  assign w_op_start   = op_load && (r_state == IDLE);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Layer sequencing; sched_done marks the DRAIN->IDLE cycle.
  always_comb begin
    w_state_nxt = r_state;
    sched_done  = 1'b0;
    case (r_state)
      IDLE:    if (op_load) w_state_nxt = RUN;
      RUN:     if (layer_end) w_state_nxt = DRAIN;
      DRAIN: begin
        if (w_drained) begin
          w_state_nxt = IDLE;
          sched_done  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_ram_type <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_pd   <= '0;
      r_stall    <= '0;
    end else begin
      if (w_op_start) r_ram_type <= reg2dp_src_ram_type;
      if (w_accept) begin
        r_out_vld <= 1'b1;
        r_out_pd  <= ig_req_pd;
      end else if (r_out_vld && w_sel_ready) begin
        r_out_vld <= 1'b0;
      end
      if (w_op_start) begin
        r_stall <= '0;
      end else if ((r_state == RUN) && ig_req_valid && !ig_req_ready && (r_stall != '1)) begin
        r_stall <= r_stall + 32'd1;
      end
    end
  end

  assign cdp2mcif_rd_req_valid  = r_out_vld && r_ram_type;
  assign cdp2mcif_rd_req_pd     = r_ram_type ? r_out_pd : '0;
  assign cdp2cvif_rd_req_valid  = r_out_vld && !r_ram_type;
  assign cdp2cvif_rd_req_pd     = r_ram_type ? '0 : r_out_pd;
  assign dp2reg_perf_read_stall = r_stall;

`ifdef NVDLA_CDP_RDMA_CDT_CHK_EN
  logic w_ovf;
  logic r_cdt_err;

  nv_nvdla_cdp_rdma_cdt_cnt #(
    .LAT_FIFO_DEPTH(LAT_FIFO_DEPTH),
    .CDT_W         (CDT_W)
  ) u_cdt_cnt (
    .clk        (nvdla_core_clk),
    .rst_n      (nvdla_core_rstn),
    .i_acc      (w_accept),
    .i_need     (w_need),
    .i_pop_a    (mcif_cdt_pop),
    .i_pop_b    (cvif_cdt_pop),
    .o_ovf      (w_ovf),
    .o_cdt_avail(w_cdt_avail)
  );

  // Sticky: over-return, unservable request, or restart mid-layer.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_cdt_err <= 1'b0;
    end else if (w_ovf || (ig_req_valid && (w_need > NEED_W'(LAT_FIFO_DEPTH))) ||
                 (op_load && (r_state != IDLE))) begin
      r_cdt_err <= 1'b1;
    end
  end

  assign cdt_err = r_cdt_err;
`else
  nv_nvdla_cdp_rdma_cdt_cnt #(
    .LAT_FIFO_DEPTH(LAT_FIFO_DEPTH),
    .CDT_W         (CDT_W)
  ) u_cdt_cnt (
    .clk        (nvdla_core_clk),
    .rst_n      (nvdla_core_rstn),
    .i_acc      (w_accept),
    .i_need     (w_need),
    .i_pop_a    (mcif_cdt_pop),
    .i_pop_b    (cvif_cdt_pop),
    .o_cdt_avail(w_cdt_avail)
  );

  assign cdt_err = 1'b0;
`endif

endmodule

// File: doc/nv_nvdla_cdp_rdma_cdt_sched.md
Name: nv_nvdla_cdp_rdma_cdt_sched

Overview:
Credit-based read-request scheduler between the CDP RDMA ingress request generator and the two memory read clients, mcif and cvif. It routes each request to one client, selected by the latched source RAM type. It gates issue against the free space of the egress latency FIFO, counting credits returned by cdt_lat_fifo_pop. It also sequences the layer with an IDLE/RUN/DRAIN state machine and produces the read-stall performance count.

Parameters:
LAT_FIFO_DEPTH, 256, egress latency FIFO depth in 64B atoms, i.e. the total credits.
CDT_W, 9, credit counter width; must satisfy 2^CDT_W > LAT_FIFO_DEPTH.
REQ_PD_W, 79, request payload width: [63:0] address, [78:64] size (atoms minus 1).

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rstn  in  1  asynchronous active-low reset
op_load  in  1  one-cycle layer start pulse
reg2dp_src_ram_type  in  1  1 = mcif, 0 = cvif; sampled on op_load
layer_end  in  1  pulse: ingress has issued the last request of the layer
ig_req_valid  in  1  request valid
ig_req_ready  out  1  request accepted
ig_req_pd  in  79  request payload
cdp2mcif_rd_req_valid  out  1  mcif request valid
cdp2mcif_rd_req_ready  in  1  mcif ready
cdp2mcif_rd_req_pd  out  79  mcif payload
cdp2cvif_rd_req_valid  out  1  cvif request valid
cdp2cvif_rd_req_ready  in  1  cvif ready
cdp2cvif_rd_req_pd  out  79  cvif payload
mcif_cdt_pop  in  1  one credit returned (mcif path)
cvif_cdt_pop  in  1  one credit returned (cvif path)
sched_done  out  1  one-cycle pulse when drain completes
dp2reg_perf_read_stall  out  32  stall cycle count
cdt_err  out  1  sticky error flag (optional feature only)

Behaviour:
- Reset values: all outputs 0; state IDLE; cdt_avail = LAT_FIFO_DEPTH; output register empty; ram_type_q = 0.
- FSM:
  - IDLE -> RUN on op_load. op_load latches ram_type_q and clears the stall counter.
  - RUN -> DRAIN on layer_end. layer_end coincident with the final acceptance is legal.
  - DRAIN -> IDLE when the output register is empty and cdt_avail == LAT_FIFO_DEPTH; sched_done pulses on that transition cycle.
  - op_load outside IDLE is ignored.
- need = ig_req_pd[78:64] + 1, computed at 16 bits.
- ig_req_ready = (state==RUN) && (!out_vld || sel_ready) && (need <= cdt_avail).
- Acceptance (ig_req_valid && ig_req_ready) loads the single-entry output register. Latency is 1 cycle from acceptance to client valid.
- Output register holds pd stable while not ready.
- Only the client selected by ram_type_q sees valid; the other valid stays 0 and its pd is driven 0.
- Credit update each cycle: cdt_avail_next = cdt_avail - (accept ? need : 0) + mcif_cdt_pop + cvif_cdt_pop.
  - Both pops in the same cycle add 2.
  - A pop coincident with an acceptance applies both.
  - Credits are decremented at acceptance, not at client handshake.
- A request with need > LAT_FIFO_DEPTH is illegal; it stalls indefinitely.
- Stall counter:
  - Increments when state==RUN && ig_req_valid && !ig_req_ready.
  - Saturates at 0xFFFF_FFFF.
  - Holds its value after the layer until the next op_load.
- Pops arriving in IDLE still update cdt_avail; the result is clamped to LAT_FIFO_DEPTH.
- An asynchronous reset mid-layer drops any pending request and restores the reset values above.

Optional Feature:
NVDLA_CDP_RDMA_CDT_CHK_EN.
- Defined: cdt_err is set and held until reset when any of the following occurs:
  - a pop would make cdt_avail exceed LAT_FIFO_DEPTH;
  - ig_req_valid is presented with need > LAT_FIFO_DEPTH;
  - op_load arrives outside IDLE.
- Undefined: cdt_err is tied 0 and no check logic is built; the IDLE-state clamp remains.

Decomposition:
- Shared package nv_nvdla_cdp_rdma_pkg holds:
  - FSM state enum (IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2);
  - REQ_PD_W, address and size field bit positions;
  - LAT_FIFO_DEPTH default.
- One sub-module, nv_nvdla_cdp_rdma_cdt_cnt: the credit counter with multi-pop add, need subtract and clamp/error detect.

Test Plan:
- Reset, then op_load with ram_type=1; send a size=3 request -> mcif valid next cycle with identical pd, cvif valid 0, cdt_avail 256 -> 252.
- ram_type=0, DEPTH 256; back-to-back size=63 requests with no pops -> four accepted; fifth stalls with ready=0; stall counter increments each cycle; one pop does not release it; 64 pops do.
- Same-cycle acceptance (size=0) with mcif_cdt_pop and cvif_cdt_pop both 1 -> cdt_avail net +1.
- layer_end, then return all outstanding credits -> sched_done pulses exactly once when cdt_avail reaches 256; state returns to IDLE.
- Client ready held 0 for 10 cycles -> pd stable, ig_req_ready 0, and the stall counter counts only while ig_req_valid=1.
- With NVDLA_CDP_RDMA_CDT_CHK_EN defined: a pop with cdt_avail=256 -> cdt_err=1 and sticky; assert nvdla_core_rstn mid-RUN -> all outputs 0, cdt_avail 256.
